// File: rtl/ecc_drain_pkg.sv
// Shared sizing, types and helpers for the ECC output drain.
// The parity helper is only used when ECC_DRAIN_PARITY_EN is defined.
package ecc_drain_pkg;

    localparam int INFO_NUM = 256;
    localparam int ADC_BIT  = 3;
    localparam int OUT_PAR  = 32;
    localparam int BEATS    = INFO_NUM / OUT_PAR;
    localparam int BEAT_BIT = $clog2(BEATS);
    localparam int SYM_W    = INFO_NUM * ADC_BIT;
    localparam int BEAT_W   = OUT_PAR * ADC_BIT;

    localparam logic [BEAT_BIT-1:0] LAST_BEAT = BEAT_BIT'(BEATS - 1);

    typedef logic [ADC_BIT-1:0] sym_t;
    typedef sym_t [OUT_PAR-1:0] beat_t;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    function automatic logic [OUT_PAR-1:0] beat_parity(input beat_t b);
        logic [OUT_PAR-1:0] p;
        p = '0;
        for (int k = 0; k < OUT_PAR; k++) begin
            p[k] = ^b[k];
        end
        return p;
    endfunction

endpackage

// File: rtl/ecc_drain_bank.sv
// One codeword buffer: full-width load register with a beat-index read mux.
module ecc_drain_bank
    import ecc_drain_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_load,
    input  logic [SYM_W-1:0]    i_data,
    input  logic [BEAT_BIT-1:0] i_beat,
    output beat_t               o_beat
);

    logic [BEATS-1:0][BEAT_W-1:0] r_mem;

    // Contents are only meaningful while the owning bank is FULL, so no reset.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_mem <= i_data;
        end
    end

    assign o_beat = r_mem[i_beat];

endmodule

// File: rtl/ecc_output_drain.sv
// Ping-pong capture of decoded symbols, drained as OUT_PAR-symbol beats over valid/ready.
// Optional ECC_DRAIN_PARITY_EN adds a per-symbol parity output registered with the data.
module ecc_output_drain
    import ecc_drain_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_dec_ready,
    input  logic [SYM_W-1:0]    i_dec_symbol,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [BEAT_W-1:0]   o_out_data,
    output logic                o_out_last,
`ifdef ECC_DRAIN_PARITY_EN
    output logic [OUT_PAR-1:0]  o_out_parity,
`endif
    output logic                o_overflow,
    output bank_state_e         o_dbg_bank0_state,
    output bank_state_e         o_dbg_bank1_state
);

    // Handshake: a beat moves on every rising clk where o_out_valid & i_out_ready;
    // while o_out_valid & !i_out_ready the beat, o_out_last and parity hold.

    logic                r_ready_q;
    logic                r_wr_sel;
    logic                r_rd_sel;
    logic [BEAT_BIT-1:0] r_beat;
    bank_state_e         r_bank_state [2];
    logic                r_out_valid;
    beat_t               r_out_data;
    logic                r_out_last;
    logic                r_overflow;

    logic                         w_capture;
    logic                         w_xfer;
    logic                         w_release;
    logic                         w_drop;
    logic [1:0]                   w_load;
    bank_state_e                  w_bank_next [2];
    logic                         w_rd_sel_next;
    logic [BEAT_BIT-1:0]          w_beat_next;
    logic                         w_valid_next;
    beat_t                        w_data_next;
    beat_t                        w_bank_beat [2];
    logic [BEATS-1:0][BEAT_W-1:0] w_in_beats;

    assign w_in_beats = i_dec_symbol;
    assign w_capture  = i_enable & i_dec_ready & ~r_ready_q;
    assign w_xfer     = r_out_valid & i_out_ready;
    assign w_release  = w_xfer & (r_beat == LAST_BEAT);

    always_comb begin
        w_load = '0;
        w_drop = 1'b0;
        for (int b = 0; b < 2; b++) begin
            w_bank_next[b] = r_bank_state[b];
            if (w_release && (r_rd_sel == 1'(b))) begin
                w_bank_next[b] = BANK_EMPTY;
            end
        end
        // Releasing first lets a capture land in the bank freed by the same edge.
        if (w_capture) begin
            if (w_bank_next[r_wr_sel] == BANK_EMPTY) begin
                w_load[r_wr_sel]      = 1'b1;
                w_bank_next[r_wr_sel] = BANK_FULL;
            end else begin
                w_drop = 1'b1;
            end
        end
        w_rd_sel_next = r_rd_sel ^ w_release;
        w_beat_next   = w_release ? '0 : (w_xfer ? r_beat + 1'b1 : r_beat);
        w_valid_next  = (w_bank_next[w_rd_sel_next] == BANK_FULL);
        // A bank loaded this edge is not in its register yet; bypass from the input.
        w_data_next   = w_load[w_rd_sel_next] ? w_in_beats[w_beat_next]
                                              : w_bank_beat[w_rd_sel_next];
    end

    ecc_drain_bank u_bank0 (
        .i_clk  (i_clk),
        .i_load (w_load[0]),
        .i_data (i_dec_symbol),
        .i_beat (w_beat_next),
        .o_beat (w_bank_beat[0])
    );

    ecc_drain_bank u_bank1 (
        .i_clk  (i_clk),
        .i_load (w_load[1]),
        .i_data (i_dec_symbol),
        .i_beat (w_beat_next),
        .o_beat (w_bank_beat[1])
    );

    // History follows the level through reset so a READY held high is never a new result.
    always_ff @(posedge i_clk) begin
        r_ready_q <= i_dec_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_sel        <= 1'b0;
            r_rd_sel        <= 1'b0;
            r_beat          <= '0;
            r_bank_state[0] <= BANK_EMPTY;
            r_bank_state[1] <= BANK_EMPTY;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_last      <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            if (|w_load) begin
                r_wr_sel <= ~r_wr_sel;
            end
            r_rd_sel        <= w_rd_sel_next;
            r_beat          <= w_beat_next;
            r_bank_state[0] <= w_bank_next[0];
            r_bank_state[1] <= w_bank_next[1];
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_out_valid <= w_valid_next;
            r_out_last  <= w_valid_next & (w_beat_next == LAST_BEAT);
            if (w_valid_next) begin
                r_out_data <= w_data_next;
            end
        end
    end

`ifdef ECC_DRAIN_PARITY_EN
    logic [OUT_PAR-1:0] r_out_parity;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_parity <= '0;
        end else if (w_valid_next) begin
            r_out_parity <= beat_parity(w_data_next);
        end
    end

    assign o_out_parity = r_out_parity;
`endif

    assign o_out_valid       = r_out_valid;
    assign o_out_data        = r_out_data;
    assign o_out_last        = r_out_last;
    assign o_overflow        = r_overflow;
    assign o_dbg_bank0_state = r_bank_state[0];
    assign o_dbg_bank1_state = r_bank_state[1];

endmodule
